// File: rtl/seg_display_scan.sv
// Four-digit multiplexed seven-segment scanner. Each frame it takes one snapshot of the inputs, so a digit never changes part way through a frame.
// Define SEG_LZ_BLANK_EN to build in leading-zero blanking.
module seg_display_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] dig_0,
    input  logic [3:0] dig_1,
    input  logic [3:0] dig_2,
    input  logic [3:0] dig_3,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_OFF = 7'b1111111;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       idx_reg;
    logic [1:0]       idx_next;
    logic [3:0]       snap_dig_reg  [4];
    logic [3:0]       snap_dig_next [4];
    logic [3:0]       snap_dp_reg;
    logic [3:0]       snap_dp_next;
    logic [3:0]       dig_in        [4];
    logic [6:0]       glyph_next    [4];
    logic [3:0]       blank_mask;
    logic [6:0]       seg_sel;
    logic             cnt_wrap;
    logic             load_snap;

    logic [3:0]       an_reg;
    logic [6:0]       seg_reg;
    logic             dp_reg;
    logic             frame_tick_reg;

    assign dig_in[0] = dig_0;
    assign dig_in[1] = dig_1;
    assign dig_in[2] = dig_2;
    assign dig_in[3] = dig_3;

    assign cnt_wrap     = (cnt_reg == CNT_MAX);
    assign cnt_next     = cnt_wrap ? '0 : cnt_reg + 1'b1;
    assign idx_next     = cnt_wrap ? idx_reg + 2'd1 : idx_reg;
    assign load_snap    = cnt_wrap && (idx_reg == 2'd3);
    assign snap_dp_next = load_snap ? dp_in : snap_dp_reg;

    // Outputs are decoded from the next-state values so the registered
    // outputs line up with cnt/idx/snapshot in the same cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign snap_dig_next[gi] = load_snap ? dig_in[gi] : snap_dig_reg[gi];
            assign glyph_next[gi]    = glyph(snap_dig_next[gi]);
        end
    endgenerate

`ifdef SEG_LZ_BLANK_EN
    logic [3:0] digit_zero;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lz
            assign digit_zero[gi] = (snap_dig_next[gi] == 4'd0) && !snap_dp_next[gi];
            if (gi == 0) begin : g_keep
                assign blank_mask[gi] = 1'b0;
            end else begin : g_blank
                assign blank_mask[gi] = &digit_zero[3:gi];
            end
        end
    endgenerate
`else
    assign blank_mask = 4'b0000;
`endif

    assign seg_sel = blank_mask[idx_next] ? SEG_OFF : glyph_next[idx_next];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            snap_dp_reg    <= '0;
            for (int i = 0; i < 4; i++) snap_dig_reg[i] <= '0;
            an_reg         <= 4'b1111;
            seg_reg        <= SEG_OFF;
            dp_reg         <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else if (!en) begin
            an_reg         <= 4'b1111;
            seg_reg        <= SEG_OFF;
            dp_reg         <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            snap_dp_reg    <= snap_dp_next;
            for (int i = 0; i < 4; i++) snap_dig_reg[i] <= snap_dig_next[i];
            frame_tick_reg <= load_snap;
            if (cnt_wrap) begin
                an_reg  <= 4'b1111;
                seg_reg <= SEG_OFF;
                dp_reg  <= 1'b1;
            end else begin
                an_reg  <= ~(4'b0001 << idx_next);
                seg_reg <= seg_sel;
                dp_reg  <= ~snap_dp_next[idx_next];
            end
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_tick = frame_tick_reg;

endmodule
